// File: rtl/layer_pkg.sv
// Shared types and helpers for the parallel-MAC fully-connected layer.
// Optional build macro: LAYER_SAT_EN selects clamping instead of wrapping
// when the ReLU output is narrowed to the data width.
package layer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    MAC,
    DRAIN,
    OUT
  } state_t;

  // Widest accumulator relu_sat can take; callers sign-extend into this.
  localparam int ACC_MAX = 64;

  // ReLU followed by narrowing to t bits. The accumulator arrives
  // sign-extended to ACC_MAX bits; the caller keeps the low t bits.
  function automatic logic [ACC_MAX-1:0] relu_sat(input logic signed [ACC_MAX-1:0] acc,
                                                 input int t);
    logic [ACC_MAX-1:0] r;
`ifdef LAYER_SAT_EN
    logic signed [ACC_MAX-1:0] max_pos;
    max_pos = $signed((64'd1 << (t - 1)) - 64'd1);
    if (acc < 0) begin
      r = '0;
    end else if (acc > max_pos) begin
      r = max_pos;
    end else begin
      r = acc;
    end
`else
    if (acc < 0) begin
      r = '0;
    end else begin
      r = acc & ((64'd1 << t) - 64'd1);
    end
`endif
    return r;
  endfunction

endpackage

// File: rtl/layer_mac_lane.sv
// One multiply-accumulate lane: on the first data beat of a pass the
// accumulator is seeded with the sign-extended bias, every beat adds the
// sign-extended T x T product.
module layer_mac_lane #(
  parameter int T    = 16,
  parameter int ACCW = 36
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init,
  input  logic                   en,
  input  logic signed [T-1:0]    x_val,
  input  logic signed [T-1:0]    w_val,
  input  logic signed [T-1:0]    b_val,
  output logic signed [ACCW-1:0] acc
);

  logic signed [2*T-1:0]  prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] base;

  assign prod     = x_val * w_val;
  assign prod_ext = {{(ACCW-2*T){prod[2*T-1]}}, prod};
  assign base     = init ? {{(ACCW-T){b_val[T-1]}}, b_val} : acc;

  // Accumulate one product per enabled beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= base + prod_ext;
    end
  end

endmodule

// File: rtl/layer_par_mac.sv
// Fully-connected layer y = ReLU(W*x + b) with P parallel MAC lanes.
// x arrives on a valid/ready stream and is kept in a local RAM; each pass
// replays it against P weight rows read from external 1-cycle ROMs, then
// streams the P results out. Build macro LAYER_SAT_EN: clamp results that
// exceed the T-bit positive range; otherwise the low T bits are kept.
//
// Handshake: a word moves on either stream only on a clock edge where
// valid && ready are both high; a producer holds valid and its data
// stable until that edge, and ready never depends on valid in this block.
module layer_par_mac
  import layer_pkg::*;
#(
  parameter int  M = 8,
  parameter int  N = 10,
  parameter int  T = 16,
  parameter int  P = 2,
  localparam int ACCW  = 2*T + $clog2(N+1),
  localparam int NPASS = M / P,
  localparam int WAW   = $clog2(NPASS*N),
  localparam int BAW   = (NPASS > 1) ? $clog2(NPASS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [T-1:0]     data_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [T-1:0]     data_out,
  output logic [WAW-1:0]   w_addr,
  input  logic [P*T-1:0]   w_data,
  output logic [BAW-1:0]   b_addr,
  input  logic [P*T-1:0]   b_data,
  output logic             busy
);

  localparam int KW = $clog2(N+1);
  localparam int XA = $clog2(N);
  localparam int LW = (P > 1) ? $clog2(P) : 1;

  if (M % P != 0) begin : g_bad_mp
    $error("layer_par_mac: M must be a multiple of P");
  end
  if (P < 1 || P > M) begin : g_bad_p
    $error("layer_par_mac: P must be in 1..M");
  end
  if (N < 2) begin : g_bad_n
    $error("layer_par_mac: N must be at least 2");
  end
  if (ACCW > ACC_MAX) begin : g_bad_accw
    $error("layer_par_mac: accumulator wider than relu_sat supports");
  end

  state_t               state;
  logic [KW-1:0]        k;
  logic [BAW-1:0]       pass;
  logic [LW-1:0]        out_lane;
  logic [LW-1:0]        ld_lane;
  logic                 x_last;
  logic                 x_wr_en;
  logic [XA-1:0]        x_wr_addr;
  logic [T-1:0]         x_wr_data;
  logic [T-1:0]         x_mem [N];
  logic signed [T-1:0]  x_q;
  logic                 mac_d1;
  logic                 first_d1;
  logic signed [ACCW-1:0] acc_all [P];
  logic signed [ACCW-1:0] acc_sel;
  logic [T-1:0]         y_next;

  assign b_addr = pass;
  assign busy   = (state != IDLE);

  // x RAM write port: accepted words land one cycle after the handshake.
  always_ff @(posedge clk) begin
    if (x_wr_en) begin
      x_mem[x_wr_addr] <= x_wr_data;
    end
  end

  // x RAM read port: address is the MAC step counter, data one cycle later
  // alongside the matching ROM word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
    end else begin
      x_q <= $signed(x_mem[k[XA-1:0]]);
    end
  end

  for (genvar p = 0; p < P; p++) begin : g_lane
    layer_mac_lane #(
      .T    (T),
      .ACCW (ACCW)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .init  (first_d1),
      .en    (mac_d1),
      .x_val (x_q),
      .w_val ($signed(w_data[p*T +: T])),
      .b_val ($signed(b_data[p*T +: T])),
      .acc   (acc_all[p])
    );
  end

  // Pick the lane to load into the output register next and reduce it.
  always_comb begin
    ld_lane = m_valid ? LW'(out_lane + 1'b1) : out_lane;
    acc_sel = acc_all[0];
    for (int p = 1; p < P; p++) begin
      if (ld_lane == LW'(p)) begin
        acc_sel = acc_all[p];
      end
    end
    y_next = T'(relu_sat(ACC_MAX'(acc_sel), T));
  end

  // Control FSM with registered handshake outputs and ROM addresses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      data_out  <= '0;
      w_addr    <= '0;
      pass      <= '0;
      k         <= '0;
      out_lane  <= '0;
      x_last    <= 1'b0;
      x_wr_en   <= 1'b0;
      x_wr_addr <= '0;
      x_wr_data <= '0;
      mac_d1    <= 1'b0;
      first_d1  <= 1'b0;
    end else begin
      x_wr_en  <= 1'b0;
      mac_d1   <= (state == MAC);
      first_d1 <= (state == MAC) && (k == '0);
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            x_wr_en   <= 1'b1;
            x_wr_addr <= '0;
            x_wr_data <= data_in;
            k         <= KW'(1);
            state     <= LOAD_X;
          end
        end
        LOAD_X: begin
          if (x_last) begin
            // Final write has committed; start the first pass.
            x_last <= 1'b0;
            k      <= '0;
            w_addr <= '0;
            pass   <= '0;
            state  <= MAC;
          end else if (s_valid && s_ready) begin
            x_wr_en   <= 1'b1;
            x_wr_addr <= k[XA-1:0];
            x_wr_data <= data_in;
            k         <= k + 1'b1;
            if (k == KW'(N-1)) begin
              x_last  <= 1'b1;
              s_ready <= 1'b0;
            end
          end
        end
        MAC: begin
          if (k == KW'(N-1)) begin
            k     <= '0;
            state <= DRAIN;
          end else begin
            k      <= k + 1'b1;
            w_addr <= w_addr + 1'b1;
          end
        end
        DRAIN: begin
          out_lane <= '0;
          state    <= OUT;
        end
        OUT: begin
          if (!m_valid) begin
            data_out <= y_next;
            m_valid  <= 1'b1;
          end else if (m_ready) begin
            if (out_lane == LW'(P-1)) begin
              m_valid  <= 1'b0;
              out_lane <= '0;
              if (pass == BAW'(NPASS-1)) begin
                pass    <= '0;
                w_addr  <= '0;
                s_ready <= 1'b1;
                state   <= IDLE;
              end else begin
                // w_addr holds pass*N+N-1, so +1 is the next pass base.
                pass   <= pass + 1'b1;
                w_addr <= w_addr + 1'b1;
                k      <= '0;
                state  <= MAC;
              end
            end else begin
              out_lane <= out_lane + 1'b1;
              data_out <= y_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_par_mac.sv
// Bench for layer_par_mac: directed vectors, ROM models, scoreboard monitor.
module tb_layer_par_mac;

  localparam int M = 8;
  localparam int N = 10;
  localparam int T = 16;
  localparam int P = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           s_valid;
  logic           s_ready;
  logic [T-1:0]   data_in;
  logic           m_valid;
  logic           m_ready;
  logic [T-1:0]   data_out;
  logic [5:0]     w_addr;
  logic [P*T-1:0] w_data = '0;
  logic [1:0]     b_addr;
  logic [P*T-1:0] b_data = '0;
  logic           busy;

  layer_par_mac #(.M(M), .N(N), .T(T), .P(P)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .busy     (busy)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ROM models (1-cycle read) ----------------
  logic [T-1:0] wmat [0:M-1][0:N-1];
  logic [T-1:0] bvec [0:M-1];

  always @(posedge clk) begin
    for (int p = 0; p < P; p++) begin
      int wa;
      int row;
      wa  = int'(w_addr);
      row = (wa / N) * P + p;
      if (row < M) w_data[p*T +: T] <= wmat[row][wa % N];
      b_data[p*T +: T] <= bvec[int'(b_addr) * P + p];
    end
  end

  // ---------------- scoreboard state ----------------
  logic [T-1:0] exp_q[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  rdy_mode = 0;
  bit  first_pending = 0;
  bit  pass_pending = 0;
  bit  mac_window = 0;
  int  acc_cyc = 0;
  int  pass_acc_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor ----------------
  bit           prev_mv = 0;
  bit           prev_stall = 0;
  logic [T-1:0] prev_data = '0;
  int           out_idx = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_mv = 0; prev_stall = 0; out_idx = 0;
      pass_pending = 0; first_pending = 0; mac_window = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data", 64'(data_out), 64'(prev_data));
      end
      if (m_valid && !prev_mv) begin
        if (first_pending) begin
          check("first_latency", 64'(cyc - acc_cyc), 64'(N + 3));
          first_pending = 0;
        end else if (pass_pending) begin
          check("pass_latency", 64'(cyc - pass_acc_cyc), 64'(N + 2));
          pass_pending = 0;
        end
      end
      if (mac_window) check("s_ready_low", 64'(s_ready), 64'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL y_unexpected: got %0d, expected no output", data_out);
        end else begin
          logic [T-1:0] e;
          e = exp_q.pop_front();
          check($sformatf("y[%0d]", out_idx), 64'(data_out), 64'(e));
        end
        if ((out_idx % P) == P-1 && out_idx != M-1) begin
          pass_pending = 1;
          pass_acc_cyc = cyc + 1;
        end
        if (out_idx == M-1) begin
          mac_window = 0;
          out_idx = 0;
        end else begin
          out_idx++;
        end
      end
      prev_mv    = m_valid;
      prev_stall = m_valid && !m_ready;
      prev_data  = data_out;
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
    end
  end

  // ---------------- driver tasks ----------------
  // wsel: 0 all 1, 1 all -1, 2 all 32767, 3 even rows 2 / odd rows -1
  // bsel: 0 zero, 1 -32, 2 3*i, 3 i
  task automatic load_rom(input int wsel, input int bsel);
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        case (wsel)
          0: wmat[i][j] = 16'd1;
          1: wmat[i][j] = 16'hFFFF;
          2: wmat[i][j] = 16'd32767;
          default: wmat[i][j] = (i % 2 == 0) ? 16'd2 : 16'hFFFF;
        endcase
      end
      case (bsel)
        0: bvec[i] = 16'd0;
        1: bvec[i] = 16'hFFE0;
        2: bvec[i] = 16'(3 * i);
        default: bvec[i] = 16'(i);
      endcase
    end
  endtask

  task automatic send_word(input logic [T-1:0] d, output bit ok);
    int g;
    g = 0;
    ok = 1;
    s_valid = 1'b1;
    data_in = d;
    @(negedge clk);
    while (!s_ready) begin
      g++;
      if (g > 300) begin
        ok = 0;
        s_valid = 1'b0;
        flag_fail("s_ready_wait");
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // xsel: 0 all 1, 1 all 32767, 2 x[j] = j+1
  task automatic send_vector(input int xsel, input bit gap);
    bit ok;
    for (int j = 0; j < N; j++) begin
      logic [T-1:0] d;
      case (xsel)
        0: d = 16'd1;
        1: d = 16'd32767;
        default: d = 16'(j + 1);
      endcase
      send_word(d, ok);
      if (!ok) return;
      if (gap && j != N-1) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    acc_cyc = cyc;
    first_pending = 1;
    mac_window = 1;
  endtask

  task automatic push_exp(input int row, input int val);
    exp_q.push_back(16'(val));
    if (row < 0) $display("bad row");
  endtask

  task automatic wait_done(input string name);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) flag_fail(name);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int g;
    reset = 1'b1;
    s_valid = 1'b0;
    data_in = '0;
    load_rom(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_w_addr", 64'(w_addr), 64'd0);
    check("rst_b_addr", 64'(b_addr), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: ones everywhere -> every y is 10
    load_rom(0, 0);
    for (int i = 0; i < M; i++) push_exp(i, 10);
    send_vector(0, 0);
    wait_done("t1_done");

    // 2a: b=-32, W=-1, x=1 -> -42 -> 0
    load_rom(1, 1);
    for (int i = 0; i < M; i++) push_exp(i, 0);
    send_vector(0, 0);
    wait_done("t2a_done");

    // 2b: b=-32, W=+1, x=1 -> -22 -> 0
    load_rom(0, 1);
    for (int i = 0; i < M; i++) push_exp(i, 0);
    send_vector(0, 0);
    wait_done("t2b_done");

    // row order: b[i]=3i, W=1, x=1 -> 10+3i
    load_rom(0, 2);
    for (int i = 0; i < M; i++) push_exp(i, 10 + 3 * i);
    send_vector(0, 0);
    wait_done("order_done");

    // 3: 10 * 32767^2 = 0x2_7FF6_000A
    load_rom(2, 0);
`ifdef LAYER_SAT_EN
    for (int i = 0; i < M; i++) push_exp(i, 32767);
`else
    for (int i = 0; i < M; i++) push_exp(i, 10);
`endif
    send_vector(1, 0);
    wait_done("t3_done");

    // 4: backpressure, x=j+1 (sum 55), b=3i -> 55+3i
    rdy_mode = 1;
    load_rom(0, 2);
    for (int i = 0; i < M; i++) push_exp(i, 55 + 3 * i);
    send_vector(2, 0);
    wait_done("t4_done");
    rdy_mode = 0;

    // 5: same vector with 1-of-3 input gaps -> same results
    for (int i = 0; i < M; i++) push_exp(i, 55 + 3 * i);
    send_vector(2, 1);
    wait_done("t5_done");

    // per-lane weights: even rows 2*55+i, odd rows -55+i -> 0
    load_rom(3, 3);
    for (int i = 0; i < M; i++) push_exp(i, (i % 2 == 0) ? 110 + i : 0);
    send_vector(2, 0);
    wait_done("lanes_done");

    // 6: reset during pass 2, then a clean vector
    load_rom(0, 2);
    for (int i = 0; i < M; i++) push_exp(i, 10 + 3 * i);
    send_vector(0, 0);
    g = 0;
    while (b_addr != 2'd2 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("t6_reach_pass2", 64'(b_addr), 64'd2);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("t6_m_valid", 64'(m_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_s_ready", 64'(s_ready), 64'd0);
    check("t6_w_addr", 64'(w_addr), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < M; i++) push_exp(i, 10 + 3 * i);
    send_vector(0, 0);
    wait_done("t6_done");

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
